// File: rtl/spi_controller.sv
// SPI mode-0 initiator: one 16-bit frame {rw, addr, wdata} per request.
// Drives sclk/copi/ncs from clk; captures cipo during the data byte.
module spi_controller #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       cipo,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [15:0]   shreg;
    logic [7:0]    cap;
    logic          last;

    assign last = (cnt == LAST);

    // Frame sequencer; every pin-facing output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            cap     <= '0;
            sclk    <= 1'b0;
            copi    <= 1'b0;
            ncs     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= {rw, addr, wdata};
                        copi    <= rw;
                        ncs     <= 1'b0;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        bit_cnt <= 4'd15;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (last) begin
                        cnt   <= '0;
                        sclk  <= 1'b1;
                        state <= SHIFT_HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    // cipo settled during the preceding low phase
                    if (cnt == '0 && !bit_cnt[3]) begin
                        cap <= {cap[6:0], cipo};
                    end
                    if (last) begin
                        cnt   <= '0;
                        sclk  <= 1'b0;
                        copi  <= shreg[14];
                        shreg <= {shreg[14:0], 1'b0};
                        state <= SHIFT_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT_LO: begin
                    if (last) begin
                        cnt <= '0;
                        if (bit_cnt == 4'd0) begin
                            copi  <= 1'b0;
                            state <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            sclk    <= 1'b1;
                            state   <= SHIFT_HI;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (last) begin
                        cnt   <= '0;
                        ncs   <= 1'b1;
                        copi  <= 1'b0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (last) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        rdata <= cap;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller.
// Scoreboard of expected frames/read data, checked by a pin monitor.
module tb_spi_controller;

    localparam int D = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rw    = 1'b0;
    logic [6:0] addr  = '0;
    logic [7:0] wdata = '0;
    logic       cipo  = 1'b0;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic       busy;
    logic       done;
    logic [7:0] rdata;

    spi_controller #(.CLK_DIV(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .rw    (rw),
        .addr  (addr),
        .wdata (wdata),
        .cipo  (cipo),
        .sclk  (sclk),
        .copi  (copi),
        .ncs   (ncs),
        .busy  (busy),
        .done  (done),
        .rdata (rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_frame_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  cipo_pat = '0;
    int          done_cnt = 0;
    int          exp_done = 0;
    int          gap_len  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pin monitor: decodes frames, times sclk levels, drives cipo.
    logic        ps = 1'b0;
    logic        pn = 1'b1;
    logic        pd = 1'b0;
    int          rises = 0;
    int          runlen = 0;
    int          busy_cnt = 0;
    int          hi_cnt = 0;
    int          nb = 0;
    logic [15:0] sh = '0;
    logic [15:0] ef;
    logic [7:0]  er;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rises = 0; runlen = 0; busy_cnt = 0; hi_cnt = 0;
                sh = '0; ps = 1'b0; pn = 1'b1; pd = 1'b0; cipo = 1'b0;
            end else begin
                chk("sclk_idle", 32'(sclk & ncs), 0);
                if (busy) busy_cnt++;
                if (!ncs && pn) begin
                    runlen = 1; rises = 0; sh = '0;
                    gap_len = hi_cnt; hi_cnt = 0;
                end else if (!ncs) begin
                    if (sclk != ps) begin
                        chk("sclk_lvl", runlen, D);
                        runlen = 1;
                    end else begin
                        runlen++;
                    end
                    if (sclk && !ps) begin
                        sh = {sh[14:0], copi};
                        rises++;
                    end
                    if (!sclk && ps) begin
                        nb = 15 - rises;
                        cipo = (nb >= 0 && nb <= 7) ? cipo_pat[nb[2:0]] : 1'b0;
                    end
                end
                if (ncs) hi_cnt++;
                if (ncs && !pn) begin
                    cipo = 1'b0;
                    chk("rises", rises, 16);
                    if (exp_frame_q.size() == 0) begin
                        chk("extra_frame", 1, 0);
                    end else begin
                        ef = exp_frame_q.pop_front();
                        chk("frame", 32'(sh), 32'(ef));
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("done_w", 32'(pd), 0);
                    chk("busy_len", busy_cnt, 35 * D);
                    chk("done_ncs", 32'(ncs), 1);
                    busy_cnt = 0;
                    if (exp_rd_q.size() == 0) begin
                        chk("extra_done", 1, 0);
                    end else begin
                        er = exp_rd_q.pop_front();
                        chk("rdata", 32'(rdata), 32'(er));
                    end
                end
                ps = sclk; pn = ncs; pd = done;
            end
        end
    end

    task automatic launch(input logic r, input logic [6:0] a,
                          input logic [7:0] d, input logic [7:0] pat);
        @(negedge clk);
        rw = r; addr = a; wdata = d; cipo_pat = pat; start = 1'b1;
        exp_frame_q.push_back({r, a, d});
        exp_rd_q.push_back(pat);
        exp_done++;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(tag, 32'(seen), 1);
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sclk", 32'(sclk), 0);
        chk("rst_copi", 32'(copi), 0);
        chk("rst_ncs", 32'(ncs), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdata", 32'(rdata), 0);

        launch(1'b1, 7'h00, 8'hF0, 8'h00);
        wait_done("wr1_done");

        launch(1'b1, 7'h04, 8'h80, 8'h00);
        repeat (48) @(negedge clk);
        rw = 1'b1; addr = 7'h02; wdata = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_done");
        repeat (2 * D + 4) @(negedge clk);
        chk("ign_busy", 32'(busy), 0);
        chk("ign_q", exp_frame_q.size(), 0);
        chk("ign_cnt", done_cnt, exp_done);

        @(negedge clk);
        rw = 1'b1; addr = 7'h01; wdata = 8'h55; cipo_pat = 8'h00;
        start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_frame_q.push_back({1'b1, 7'h01, 8'h55});
            exp_rd_q.push_back(8'h00);
            exp_done++;
        end
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("b2b_first", 32'(seen), 1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("b2b_second");
        chk("b2b_gap", 32'(gap_len >= D + 1), 1);

        launch(1'b0, 7'h03, 8'h00, 8'hA5);
        wait_done("rd_done");
        chk("rd_now", 32'(rdata), 'hA5);
        launch(1'b1, 7'h02, 8'h3C, 8'h00);
        repeat (60) @(negedge clk);
        chk("rd_hold", 32'(rdata), 'hA5);
        wait_done("wr_after_rd");
        chk("rd_clr", 32'(rdata), 0);

        launch(1'b1, 7'h05, 8'hAA, 8'h00);
        repeat (52) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ncs", 32'(ncs), 1);
        chk("abort_sclk", 32'(sclk), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        void'(exp_frame_q.pop_back());
        void'(exp_rd_q.pop_back());
        exp_done--;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        launch(1'b1, 7'h7F, 8'h12, 8'h00);
        wait_done("post_rst");
        repeat (10) @(negedge clk);
        chk("done_total", done_cnt, exp_done);
        chk("q_empty", exp_frame_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI-mode-0 initiator for the onboarding register interface. It generates SCLK, COPI and nCS from the system clock. It accepts one 16-bit frame per request: R/W bit, 7-bit address, then 8-bit data, MSB first. Its outputs drive the `spi_peripheral` pins (ui_in[0]=SCLK, ui_in[1]=COPI, ui_in[2]=nCS). It serves as the on-chip or test-harness host that programs the output-enable, PWM-enable and duty-cycle registers.

Parameters:
CLK_DIV, 4, system-clock cycles per SCLK half-period. Legal range is ≥3, because the peripheral's 2-FF synchronizer plus edge detect needs each SCLK level held ≥3 cycles.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse/level; sampled only when busy=0
rw  input  1  frame bit 15 (1=write, 0=read)
addr  input  7  register address, frame bits 14:8
wdata  input  8  write data, frame bits 7:0
cipo  input  1  serial data from peripheral; used for read capture only
sclk  output  1  SPI clock, idle low
copi  output  1  serial data to peripheral
ncs  output  1  chip select, active low, idle high
busy  output  1  transaction in progress
done  output  1  one-cycle completion pulse
rdata  output  8  data captured from cipo during bits 7:0

Behaviour:
- Reset (async, rst_n=0):
  - sclk=0, copi=0, ncs=1, busy=0, done=0, rdata=8'h00.
  - FSM goes to IDLE and counters clear.
  - Applies immediately, including mid-frame; ncs rises without completing the frame and no done pulse is issued.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP.
- IDLE:
  - If start=1, latch frame={rw,addr,wdata} into a shift register and go to SETUP.
  - busy=1 and ncs=0 from the next cycle; copi=frame[15] in the same cycle.
  - start while busy=1 is ignored; inputs are not re-sampled.
- SETUP: lasts CLK_DIV cycles; sclk=0, ncs=0. Then go to SHIFT_HI.
- SHIFT_HI:
  - sclk=1 for CLK_DIV cycles. copi is stable for the whole high phase.
  - cipo is sampled in the first cycle of SHIFT_HI; for bits 7..0 it is shifted into an internal capture register, MSB first.
- SHIFT_LO:
  - sclk=0 for CLK_DIV cycles. copi advances to the next frame bit in the first cycle of SHIFT_LO.
  - After the low phase of bit 0, go to HOLD; otherwise return to SHIFT_HI.
  - A 4-bit bit counter counts 15→0.
- HOLD: CLK_DIV cycles; sclk=0, ncs=0, copi=0. This is the hold time after the last falling edge.
- GAP:
  - ncs=1, copi=0 for CLK_DIV cycles. This guarantees minimum nCS-high time between frames.
  - Then return to IDLE with busy=0 and done=1 for that one cycle.
  - rdata is updated from the capture register in the same cycle.
- Timing totals:
  - busy is high for exactly 35×CLK_DIV cycles (140 at the default), starting the cycle after start is accepted.
  - Exactly 16 sclk rising edges occur per frame.
- Back-to-back: a start asserted in the done cycle is accepted in that cycle. Continuous start=1 yields frames separated by ≥ CLK_DIV+1 cycles of ncs=1.
- rw=0 frames are transmitted identically; wdata bits are still shifted out on copi. Only rdata is meaningful for reads.
- sclk never toggles while ncs=1.
- Frame contents are frozen at acceptance; input changes mid-frame have no effect.

Test Plan:
- Reset: hold rst_n=0, then release → sclk=0, ncs=1, copi=0, busy=0, done=0, rdata=0x00. Asserting rst_n=0 mid-frame at bit 9 → ncs=1 and sclk=0 asynchronously (same cycle); no done pulse; the next start produces a full correct frame.
- Single write, CLK_DIV=4, rw=1, addr=0x00, wdata=0xF0:
  - The monitor sampling copi on sclk rising edges decodes 16'b1_0000000_11110000.
  - Exactly 16 rising edges; busy high for 140 cycles; done pulses once; each sclk level is held 4 cycles.
- Start during busy: pulse start with addr=0x02 at cycle 50 of a frame → ignored; the frame completes with the original bits and only one done pulse occurs.
- Back-to-back: start held high with addr=0x01, wdata=0x55 → second frame begins the cycle after done; ncs high ≥5 cycles between frames; both frames decode correctly.
- Read capture: rw=0, addr=0x03, bench drives cipo with 0xA5 on falling edges during bits 7..0 → rdata=0xA5 in the done cycle; unchanged until the next done.
- Integration with spi_peripheral and pwm_peripheral on the same clk:
  - Write 0x00=0xFF, 0x02=0xFF, 0x04=0x80 → uo_out toggles at a ~50% duty cycle.
  - A write to addr=0x7F leaves all registers unchanged.
